// File: rtl/sseg_arbiter.sv
// rtl/sseg_arbiter.sv - round-robin owner arbiter with minimum dwell for the shared seven-segment display
module sseg_arbiter #(
    parameter int N     = 16,
    parameter int NREQ  = 4,
    parameter int DWELL = 10_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*N-1:0]         data,
    input  logic                      lock,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      valid,
    output logic [N-1:0]              out
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
    localparam logic [OW-1:0] LAST_RST = OW'(NREQ - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [N-1:0]      out_q, out_d;

    logic [N-1:0]      data_arr [NREQ];
    logic [NREQ-1:0]   others;
    logic [OW:0]       req_pick, oth_pick;
    logic              take;
    logic [OW-1:0]     win;

    // First set mask bit scanning base+1, base+2, ... wrapping mod NREQ; MSB flags a hit.
    function automatic logic [OW:0] rr_pick(input logic [OW-1:0] base, input logic [NREQ-1:0] mask);
        logic [OW:0]   res;
        logic [OW-1:0] idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = OW'((int'(base) + k) % NREQ);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) data_arr[i] = data[i*N +: N];
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        out_d    = out_q;
        take     = 1'b0;
        win      = '0;
        others   = req & ~grant_q;
        req_pick = rr_pick(last_q, req);
        oth_pick = rr_pick(last_q, others);

        case (state_q)
            IDLE: begin
                if (req_pick[OW]) begin
                    take = 1'b1;
                    win  = req_pick[OW-1:0];
                end
            end
            HOLD: begin
                if (!req[owner_q]) begin
                    if (oth_pick[OW]) begin
                        take = 1'b1;
                        win  = oth_pick[OW-1:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!lock && oth_pick[OW]) begin
                    take = 1'b1;
                    win  = oth_pick[OW-1:0];
                end
                // Expired dwell with no eligible competitor: counter parks at zero.
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase

        if (take) begin
            state_d = HOLD;
            grant_d = NREQ'(1) << win;
            owner_d = win;
            last_d  = win;
            cnt_d   = CNT_LOAD;
            valid_d = 1'b1;
        end

        if (state_d == HOLD) out_d = data_arr[owner_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign valid = valid_q;
    assign out   = out_q;

endmodule

// File: tb/tb_sseg_arbiter.sv
// tb/tb_sseg_arbiter.sv - directed self-checking bench for sseg_arbiter
module tb_sseg_arbiter;

    localparam int N     = 16;
    localparam int NREQ  = 4;
    localparam int DWELL = 4;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ*N-1:0] data;
    logic            lock;
    logic [NREQ-1:0] grant;
    logic [1:0]      owner;
    logic            valid;
    logic [N-1:0]    out;

    int checks;
    int failures;

    sseg_arbiter #(.N(N), .NREQ(NREQ), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .data  (data),
        .lock  (lock),
        .grant (grant),
        .owner (owner),
        .valid (valid),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = 1'b0;
        data  = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = 1'b0;
        data  = '0;
        #2;
        checks++;
        if (grant !== 4'b0000 || valid !== 1'b0 || owner !== 2'd0 || out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state grant=%b valid=%b owner=%0d out=%h required 0000/0/0/0000", grant, valid, owner, out);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0000 || valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req grant=%b valid=%b required 0000/0", grant, valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        data[15:0] = 16'h1234;
        step();
        checks++;
        if (grant !== 4'b0001 || owner !== 2'd0 || valid !== 1'b1 || out !== 16'h1234) begin
            failures++;
            $display("FAIL single_grant grant=%b owner=%0d valid=%b out=%h required 0001/0/1/1234", grant, owner, valid, out);
        end
        data[15:0] = 16'hBEEF;
        step();
        checks++;
        if (out !== 16'hBEEF) begin
            failures++;
            $display("FAIL single_data_follow out=%h required beef", out);
        end
        // Sole requester keeps the grant well past the dwell.
        for (int c = 0; c < 8; c++) step();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL single_no_self_preempt grant=%b required 0001", grant);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [15:0] exp_o;
        int          seq [6];
        do_reset();
        data[15:0]  = 16'h0001;
        data[31:16] = 16'h0002;
        data[63:48] = 16'h0004;
        seq = '{0, 1, 0, 1, 3, 0};
        req = 4'b0011;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) req = 4'b1011;
            step();
            exp_g = 4'b0001 << seq[c / 4];
            exp_o = 16'h0001 << seq[c / 4];
            if (seq[c / 4] == 3) exp_o = 16'h0004;
            checks++;
            if (grant !== exp_g || out !== exp_o) begin
                failures++;
                $display("FAIL rr_cycle%0d grant=%b out=%h required %b/%h", c, grant, out, exp_g, exp_o);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        data[15:0]  = 16'h000A;
        data[47:32] = 16'h000C;
        req = 4'b0101;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL early_first grant=%b required 0001", grant);
        end
        step();
        step();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL early_mid_dwell grant=%b required 0001", grant);
        end
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || owner !== 2'd2 || valid !== 1'b1 || out !== 16'h000C) begin
            failures++;
            $display("FAIL early_handover grant=%b owner=%0d valid=%b out=%h required 0100/2/1/000c", grant, owner, valid, out);
        end
    endtask

    task automatic test_lock();
        int bad;
        do_reset();
        lock = 1'b1;
        req  = 4'b0011;
        bad  = 0;
        for (int c = 0; c < 21; c++) begin
            step();
            if (grant !== 4'b0001) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lock_hold bad_cycles=%0d required 0 (last grant=%b)", bad, grant);
        end
        lock = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            failures++;
            $display("FAIL lock_release grant=%b owner=%0d required 0010/1", grant, owner);
        end
    endtask

    task automatic test_idle();
        do_reset();
        data[15:0]  = 16'hABCD;
        data[63:48] = 16'h3333;
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000 || valid !== 1'b0 || out !== 16'hABCD || owner !== 2'd0) begin
            failures++;
            $display("FAIL idle_hold grant=%b valid=%b out=%h owner=%0d required 0000/0/abcd/0", grant, valid, out, owner);
        end
        req = 4'b1000;
        step();
        checks++;
        if (grant !== 4'b1000 || owner !== 2'd3 || out !== 16'h3333) begin
            failures++;
            $display("FAIL idle_regrant grant=%b owner=%0d out=%h required 1000/3/3333", grant, owner, out);
        end
        req = 4'b0000;
        step();
        // last is now 3, so requester 0 wins the wrap over requester 3.
        req = 4'b1001;
        step();
        checks++;
        if (grant !== 4'b0001 || owner !== 2'd0) begin
            failures++;
            $display("FAIL idle_wrap grant=%b owner=%0d required 0001/0", grant, owner);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        data[15:0] = 16'h5555;
        req = 4'b0001;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || valid !== 1'b0 || out !== 16'h0000 || owner !== 2'd0) begin
            failures++;
            $display("FAIL async_clear grant=%b valid=%b out=%h owner=%0d required 0000/0/0000/0", grant, valid, out, owner);
        end
        req = 4'b0110;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL async_held grant=%b required 0000", grant);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL async_first_grant grant=%b owner=%0d valid=%b required 0010/1/1", grant, owner, valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_lock();
        test_idle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_arbiter.md
# sseg_arbiter

Shares the 16-bit seven-segment display between up to four requesters (counter, switch mirror, debug taps, ...) on the 10 MHz system clock. Sits between the requesting datapaths and the `sseg` driver: its `out` bus drives `sseg.in`. Arbitration is round-robin with a minimum dwell time per owner, so a human can read each value. A `lock` input freezes the current owner.

## Interface
- `N`, 16: display value width in bits; matches `sseg` `N`.
- `NREQ`, 4: number of requesters, 2..8.
- `DWELL`, 10_000_000: minimum grant duration in clk cycles before preemption (1 s at 10 MHz), ≥1.
- `clk`  in  1: system clock (10 MHz DCM output).
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  NREQ: per-requester display request, level-sensitive.
- `data`  in  NREQ*N: requester values; requester i at `data[i*N +: N]`.
- `lock`  in  1: when high, no preemption of the current owner.
- `grant`  out  NREQ: one-hot current owner; all-zero when idle.
- `owner`  out  clog2(NREQ): index of the current or last owner.
- `valid`  out  1: high while any grant is held.
- `out`  out  N: registered display value to `sseg`.

## Operation
- Reset: asynchronous on `rst_n` low, no clock edge needed. Values during reset: `grant`=0, `valid`=0, `owner`=0, `out`=0, state IDLE, dwell counter 0, round-robin pointer `last`=NREQ-1, so requester 0 has first priority.
- States:
  - IDLE: `grant`=0. `out` holds its last value; it is not cleared.
  - HOLD: exactly one grant bit set.
- Selection: pick the first set `req` bit scanning `last+1`, `last+2`, ... mod NREQ. On a grant, set `last`, `owner` and `grant` to the winner.
- IDLE → HOLD: at the first edge where `req`≠0. The winner is granted at that edge. Load the dwell counter with DWELL-1.
- HOLD, owner's `req` low:
  - Release at the next edge, regardless of the dwell count.
  - If other requests are pending, grant the next one directly (HOLD → HOLD, new owner, counter reloaded).
  - Otherwise go to IDLE.
- HOLD, owner's `req` high, counter > 0: decrement; no change of owner.
- HOLD, owner's `req` high, counter = 0:
  - If `lock`=0 and some other `req` bit is set, rotate to the next requester (scan from owner+1) and reload the counter.
  - Otherwise stay and keep the counter at 0, so preemption happens on the first edge a competitor appears or `lock` falls.
- `lock` does not block a voluntary release; it only suppresses preemption.
- The owner's own request never counts as a competitor. When only the owner requests, it keeps the grant indefinitely.
- Data path: in HOLD, at every edge `out <= data[owner]`, using the owner in effect after that edge. On a grant edge, `out` loads the new winner's data at the same edge `grant` changes.
- Width rules:
  - Dwell counter width is clog2(DWELL).
  - Index arithmetic wraps mod NREQ (NREQ need not be a power of two).
  - `req` bits ≥ NREQ do not exist; no padding is treated as a request.
- No combinational path from any input to any output; all outputs are registered.

## Timing
- Request to grant: 1 cycle. `req` sampled at edge E, then `grant`, `valid`, `owner` and `out` are updated at E.
- Owner data to `out` latency: 1 cycle.
- Minimum hold under contention: a grant made at edge E0 is held for cycles E0..E0+DWELL-1. The earliest preemption is at edge E0+DWELL.
- Voluntary release latency: 1 cycle after the owner's `req` falls. The handover to a waiting requester happens at the same edge, with no idle bubble.
- `valid` rises and falls on the same edges as the OR of `grant`.
- Reset mid-HOLD: outputs clear asynchronously. After `rst_n` rises, the first grant needs a full clock edge with `req`≠0.

## Test plan
All tests use N=16, NREQ=4, DWELL=4.
- Single requester: release reset, set `req`=0001 and `data0`=16'h1234. Required at the next edge: `grant`=0001, `owner`=0, `valid`=1, `out`=16'h1234. Change `data0` to 16'hBEEF; `out`=16'hBEEF one cycle later.
- Round-robin contention: hold `req`=0011 with `data0`=16'h0001 and `data1`=16'h0002. Required: `grant` alternates 0001 and 0010, each for exactly 4 cycles, and `out` tracks the owner. Then set `req`=1011; the order becomes 0 → 1 → 3 → 0.
- Early release: `req`=0101, owner 0. Drop `req[0]` 2 cycles after its grant. Required: `grant`=0100 at the next edge, with no wait for the dwell and no idle cycle.
- Lock: `req`=0011, `lock`=1. Required: `grant` stays 0001 for at least 20 cycles. Lower `lock`; `grant`=0010 at the next edge.
- Idle: drop all `req` while `out`=16'hABCD. Required at the next edge: `grant`=0, `valid`=0, and `out` holds 16'hABCD. A new `req`=1000 is granted after requester 3 relative to `last`.
- Async reset: assert `rst_n`=0 between clock edges while in HOLD. Required: `grant`=0, `valid`=0, `out`=0 immediately. After release with `req`=0110, the first grant goes to requester 1.
